// File: rtl/adc_frame_packer.sv
// adc_frame_packer
//   Buffers 8-bit ADC samples in a small FIFO and sends them to the UART
//   transmitter as fixed-length frames: HEADER, FRAME_LEN samples, then an
//   8-bit checksum (sum mod 256 of the sample bytes). Bytes go out one at a
//   time using the transmitter's level-enable / done-pulse handshake.
//
//   Optional feature macro: ADC_FRAME_SEQ_EN
//     When defined, a frame sequence byte follows HEADER. It is included in
//     the checksum and increments after every completed frame.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   ad_sample    ADC conversion result, stable while ad_done is high
//   ad_done      ADC conversion-complete flag (level, may stay high)
//   tx_done_sig  one-cycle pulse: transmitter finished the current byte
//   tx_data      byte presented to the transmitter
//   tx_en_sig    transmit request level
//   frame_busy   high from header load until the checksum's tx_done_sig
//   overflow     sticky: a sample was dropped because the FIFO was full
//   fifo_level   current FIFO occupancy
//
// FSM states
//   state | meaning
//   IDLE  | waiting for FRAME_LEN samples in the FIFO
//   HDR   | header byte on tx_data, waiting for tx_done_sig
//   SEQ   | sequence byte on tx_data (ADC_FRAME_SEQ_EN only)
//   DATA  | sample byte on tx_data, waiting for tx_done_sig
//   SUM   | checksum byte on tx_data, waiting for tx_done_sig
//   GAP   | one idle cycle with tx_en_sig low, then load next byte

module adc_frame_packer #(
  parameter int         FRAME_LEN  = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER     = 8'hAA
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    ad_sample,
  input  logic                          ad_done,
  input  logic                          tx_done_sig,
  output logic [7:0]                    tx_data,
  output logic                          tx_en_sig,
  output logic                          frame_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FLEN   = AW1'(FRAME_LEN);
  localparam logic [AW:0] FDEPTH = AW1'(FIFO_DEPTH);

`ifdef ADC_FRAME_SEQ_EN
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, SUM, GAP} state_t;
  localparam state_t FIRST_AFTER_HDR = SEQ;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, SUM, GAP} state_t;
  localparam state_t FIRST_AFTER_HDR = DATA;
`endif

  state_t         state;
  state_t         after_gap;
  state_t         after_sent;
  logic [AW:0]    cnt;
  logic [7:0]     csum;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           ad_done_q;
  logic           ad_done_qq;
  logic           wr_req;
  logic           pop;
  logic           full;
  logic           wr_ok;
`ifdef ADC_FRAME_SEQ_EN
  logic [7:0]     seq;
`endif

  // Rising edge of the registered conversion flag; a long ad_done level
  // therefore produces exactly one write.
  assign wr_req = ad_done_q & ~ad_done_qq;
  assign pop    = (state == GAP) && (after_gap == DATA);
  assign full   = (fifo_level == FDEPTH);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is
  // still accepted then.
  assign wr_ok  = wr_req & (~full | pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ad_done_q  <= 1'b0;
      ad_done_qq <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      ad_done_q  <= ad_done;
      ad_done_qq <= ad_done_q;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && !wr_ok) overflow <= 1'b1;
      fifo_level <= fifo_level + AW1'(wr_ok) - AW1'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= ad_sample;
  end

  // Where to go after the GAP that follows the byte now being sent.
  // cnt already counts the sample currently on tx_data.
  always_comb begin
    after_sent = SUM;
    if (state == HDR)     after_sent = FIRST_AFTER_HDR;
    else if (cnt < FLEN)  after_sent = DATA;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      after_gap  <= IDLE;
      cnt        <= '0;
      csum       <= '0;
      tx_data    <= '0;
      tx_en_sig  <= 1'b0;
      frame_busy <= 1'b0;
`ifdef ADC_FRAME_SEQ_EN
      seq        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fifo_level >= FLEN) begin
            tx_data    <= HEADER;
            tx_en_sig  <= 1'b1;
            frame_busy <= 1'b1;
            csum       <= '0;
            cnt        <= '0;
            state      <= HDR;
          end
        end
        GAP: begin
          tx_en_sig <= 1'b1;
          state     <= after_gap;
          case (after_gap)
            DATA: begin
              tx_data <= mem[rd_ptr];
              csum    <= csum + mem[rd_ptr];
              cnt     <= cnt + 1'b1;
            end
`ifdef ADC_FRAME_SEQ_EN
            SEQ: begin
              tx_data <= seq;
              csum    <= csum + seq;
            end
`endif
            default: tx_data <= csum;
          endcase
        end
        // HDR, SEQ, DATA, SUM: hold the byte until the transmitter is done.
        default: begin
          if (tx_done_sig && tx_en_sig) begin
            tx_en_sig <= 1'b0;
            if (state == SUM) begin
              frame_busy <= 1'b0;
              state      <= IDLE;
`ifdef ADC_FRAME_SEQ_EN
              seq        <= seq + 1'b1;
`endif
            end else begin
              after_gap <= after_sent;
              state     <= GAP;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer
//   Scoreboard bench for adc_frame_packer with default parameters.
//   Expected frame bytes are queued when samples are driven; a monitor pops
//   and compares on every tx_en_sig rise and checks the one-cycle gap.
//   A responder answers tx_done_sig 5 cycles after tx_en_sig rises.

`timescale 1ns/1ps

module tb_adc_frame_packer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] ad_sample;
  logic       ad_done;
  logic       tx_done_sig;
  logic [7:0] tx_data;
  logic       tx_en_sig;
  logic       frame_busy;
  logic       overflow;
  logic [3:0] fifo_level;

  logic       hold_tx = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seq_m = 8'h00;
  logic       prev_en = 1'b0;
  logic       prev_busy = 1'b0;
  int         low_cnt = 0;

  adc_frame_packer dut (
    .clk         (clk),
    .rstn        (rstn),
    .ad_sample   (ad_sample),
    .ad_done     (ad_done),
    .tx_done_sig (tx_done_sig),
    .tx_data     (tx_data),
    .tx_en_sig   (tx_en_sig),
    .frame_busy  (frame_busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: done pulse once tx_en_sig has been high 5 cycles.
  initial begin
    int age;
    age = 0;
    tx_done_sig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_sig = 1'b0;
      if (tx_en_sig && rstn) age++;
      else age = 0;
      if (age >= 5 && !hold_tx) tx_done_sig = 1'b1;
    end
  end

  // Byte monitor / scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_en   = 1'b0;
      prev_busy = 1'b0;
      low_cnt   = 0;
    end else begin
      if (tx_en_sig && !prev_en) begin
        chk("byte_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
        chk("busy_at_byte", frame_busy, 1);
        if (prev_busy) chk("gap_len", low_cnt, 1);
      end
      low_cnt   = tx_en_sig ? 0 : low_cnt + 1;
      prev_en   = tx_en_sig;
      prev_busy = frame_busy;
    end
  end

  // Queue the bytes of one frame; w holds samples first-to-last from MSB.
  task automatic expect_frame(input logic [31:0] w);
    logic [7:0] s;
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.push_back(8'hAA);
`ifdef ADC_FRAME_SEQ_EN
    exp_q.push_back(seq_m);
    sum = seq_m;
    seq_m = seq_m + 8'h01;
`endif
    for (int i = 3; i >= 0; i--) begin
      s = w[i*8 +: 8];
      exp_q.push_back(s);
      sum = sum + s;
    end
    exp_q.push_back(sum);
  endtask

  task automatic send_sample(input logic [7:0] s);
    @(posedge clk);
    #1;
    ad_sample = s;
    ad_done   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ad_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_sample(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !frame_busy && !tx_en_sig) done = 1'b1;
    end
    chk("idle_timeout", 32'(done), 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rstn = 1'b0;
    exp_q.delete();
    seq_m = 8'h00;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  initial begin
    bit reached;
    rstn      = 1'b0;
    ad_done   = 1'b0;
    ad_sample = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_en", tx_en_sig, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", fifo_level, 0);
    #2 rstn = 1'b1;

    // Basic frame: AA 10 20 30 40 A0
    expect_frame(32'h10203040);
    send_word(32'h10203040);
    wait_idle(500);

    // Checksum wrap: FF+FF+02+01 = 01 mod 256
    expect_frame(32'hFFFF0201);
    send_word(32'hFFFF0201);
    wait_idle(500);

    // Overflow: transmitter stalled, 10 samples, last two dropped
    hold_tx = 1'b1;
    expect_frame(32'h11121314);
    expect_frame(32'h15161718);
    for (int i = 1; i <= 10; i++) send_sample(8'(8'h10 + i));
    @(negedge clk);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_flag", overflow, 1);
    hold_tx = 1'b0;
    wait_idle(1000);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained", fifo_level, 0);

    // ad_done held high 20 cycles -> one write
    @(posedge clk);
    #1;
    ad_sample = 8'h77;
    ad_done   = 1'b1;
    repeat (20) @(posedge clk);
    #1 ad_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_level", fifo_level, 1);

    // Reset during the first DATA byte of a frame
    expect_frame(32'h77010203);
    send_sample(8'h01);
    send_sample(8'h02);
    send_sample(8'h03);
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 4) reached = 1'b1;
    end
    chk("abort_reach_data", 32'(reached), 1);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("abort_tx_en", tx_en_sig, 0);
    chk("abort_busy", frame_busy, 0);
    chk("abort_level", fifo_level, 0);
    exp_q.delete();
    seq_m = 8'h00;
    @(negedge clk);
    #2 rstn = 1'b1;
    chk("abort_ovf_clr", overflow, 0);
    expect_frame(32'h5A6B7C8D);
    send_word(32'h5A6B7C8D);
    wait_idle(500);

`ifdef ADC_FRAME_SEQ_EN
    // 257 frames: sequence bytes 00..FF then 00
    pulse_reset();
    for (int f = 0; f < 257; f++) begin
      expect_frame(32'h10203040);
      send_word(32'h10203040);
      wait_idle(500);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
